// File: rtl/pkt_channel_sel.sv
// Packet classifier: tags each beat with a channel chosen at SOP.
// Optional per-channel/error counters enabled by PKT_CNT_EN.
module pkt_channel_sel #(
  parameter logic [1:0]  CH_INSPECT = 2'd0,
  parameter logic [1:0]  CH_BYPASS  = 2'd1,
  parameter logic [15:0] ETH_IPV4   = 16'h0800
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] in_pkt_data,
  input  logic         in_pkt_valid,
  input  logic         in_pkt_sop,
  input  logic         in_pkt_eop,
  input  logic [5:0]   in_pkt_empty,
  output logic         in_pkt_ready,
  output logic         in_pkt_almost_full,
  output logic [511:0] out_pkt_data,
  output logic         out_pkt_valid,
  output logic         out_pkt_sop,
  output logic         out_pkt_eop,
  output logic [5:0]   out_pkt_empty,
  output logic [1:0]   out_pkt_channel,
  input  logic         out_pkt_ready,
  input  logic         out_pkt_almost_full
`ifdef PKT_CNT_EN
  ,
  output logic [31:0]  cnt_inspect,
  output logic [31:0]  cnt_bypass,
  output logic [31:0]  err_cnt
`endif
);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
    logic [1:0]   ch;
  } beat_t;

  state_t     state_q, state_d;
  logic [1:0] cur_ch_q, cur_ch_d;
  beat_t      out_q, out_d;
  logic       out_vld_q, out_vld_d;
  beat_t      skid_q, skid_d;
  logic       skid_vld_q, skid_vld_d;
  logic       rdy_q, rdy_d;
  logic       af_q;

  logic        accept;
  logic        fwd;
  logic        err_ev;
  logic        advance;
  logic [1:0]  beat_ch;
  logic [1:0]  new_ch;
  logic [15:0] ethertype;
  logic [7:0]  proto;
  beat_t       in_beat;

  assign accept    = in_pkt_valid & rdy_q;
  assign ethertype = in_pkt_data[415:400];
  assign proto     = in_pkt_data[327:320];

  always_comb begin
    new_ch = CH_BYPASS;
    if (ethertype == ETH_IPV4 &&
        (proto == 8'd6 || proto == 8'd17))
      new_ch = CH_INSPECT;
  end

  // SOP reclassifies in either state; SOP while IN_PKT is a truncation.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    beat_ch  = cur_ch_q;
    fwd      = 1'b0;
    err_ev   = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (in_pkt_sop) begin
            fwd      = 1'b1;
            cur_ch_d = new_ch;
            beat_ch  = new_ch;
            state_d  = in_pkt_eop ? IDLE : IN_PKT;
          end else begin
            err_ev = 1'b1;
          end
        end
        IN_PKT: begin
          fwd = 1'b1;
          if (in_pkt_sop) begin
            err_ev   = 1'b1;
            cur_ch_d = new_ch;
            beat_ch  = new_ch;
            state_d  = in_pkt_eop ? IDLE : IN_PKT;
          end else if (in_pkt_eop) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_beat = '{
    data:  in_pkt_data,
    sop:   in_pkt_sop,
    eop:   in_pkt_eop,
    empty: in_pkt_empty,
    ch:    beat_ch
  };

  assign advance = ~out_vld_q | out_pkt_ready;

  // Skid entry always drains first so beat order is preserved.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    unique case (1'b1)
      advance & skid_vld_q: begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = fwd;
        if (fwd) skid_d = in_beat;
      end
      advance & ~skid_vld_q: begin
        out_vld_d = fwd;
        if (fwd) out_d = in_beat;
      end
      ~advance: begin
        if (fwd) begin
          skid_d     = in_beat;
          skid_vld_d = 1'b1;
        end
      end
      default: ;
    endcase
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_ch_q   <= 2'd0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      af_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      af_q       <= out_pkt_almost_full;
    end
  end

  assign in_pkt_ready       = rdy_q;
  assign in_pkt_almost_full = af_q;
  assign out_pkt_data       = out_q.data;
  assign out_pkt_valid      = out_vld_q;
  assign out_pkt_sop        = out_q.sop;
  assign out_pkt_eop        = out_q.eop;
  assign out_pkt_empty      = out_q.empty;
  assign out_pkt_channel    = out_q.ch;

`ifdef PKT_CNT_EN
  logic [31:0] ci_q, ci_d;
  logic [31:0] cb_q, cb_d;
  logic [31:0] ec_q, ec_d;
  logic        eop_done;

  assign eop_done = out_vld_q & out_pkt_ready & out_q.eop;

  always_comb begin
    ci_d = ci_q;
    cb_d = cb_q;
    ec_d = ec_q;
    if (eop_done && out_q.ch == CH_INSPECT) ci_d = ci_q + 32'd1;
    if (eop_done && out_q.ch == CH_BYPASS)  cb_d = cb_q + 32'd1;
    if (err_ev) ec_d = ec_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ci_q <= '0;
      cb_q <= '0;
      ec_q <= '0;
    end else begin
      ci_q <= ci_d;
      cb_q <= cb_d;
      ec_q <= ec_d;
    end
  end

  assign cnt_inspect = ci_q;
  assign cnt_bypass  = cb_q;
  assign err_cnt     = ec_q;
`else
  logic unused_err;
  assign unused_err = err_ev;
`endif

endmodule

// File: doc/pkt_channel_sel.md
Name: pkt_channel_sel

Overview:
- Classifies each incoming packet at SOP and tags every beat of that packet with a 2-bit channel.
- Sits directly upstream of the two-way channel fork and drives that fork's input stream, including its channel field.
- IPv4 TCP/UDP packets go to the inspection channel; everything else goes to the bypass channel.
- Holds the channel constant for a whole packet, drops orphan beats, and provides a registered output with a skid slot.

Parameters:
- CH_INSPECT, 2'd0, channel assigned to IPv4 TCP/UDP packets.
- CH_BYPASS, 2'd1, channel assigned to all other packets.
- ETH_IPV4, 16'h0800, EtherType value that identifies IPv4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_pkt_data  in  512  beat data; byte 0 is at [511:504].
- in_pkt_valid  in  1  beat valid.
- in_pkt_sop  in  1  start of packet.
- in_pkt_eop  in  1  end of packet.
- in_pkt_empty  in  6  empty bytes on the EOP beat.
- in_pkt_ready  out  1  registered; high means a beat can be accepted this cycle.
- in_pkt_almost_full  out  1  registered copy of out_pkt_almost_full.
- out_pkt_data  out  512  registered data.
- out_pkt_valid  out  1  output valid.
- out_pkt_sop  out  1  start of packet.
- out_pkt_eop  out  1  end of packet.
- out_pkt_empty  out  6  empty bytes.
- out_pkt_channel  out  2  channel tag, constant across a packet.
- out_pkt_ready  in  1  downstream ready.
- out_pkt_almost_full  in  1  downstream almost-full.

Behaviour:
- Single clock domain: clk. rst is asynchronous and active-high.
- Reset values: every output is 0, except in_pkt_ready = 1; FSM = IDLE; skid buffer empty.
- Accept condition: a beat is accepted when in_pkt_valid & in_pkt_ready.
- Classification, performed only on an accepted SOP beat:
  - ethertype = data[415:400] (bytes 12-13); proto = data[327:320] (byte 23).
  - If ethertype == ETH_IPV4 and proto is 8'd6 or 8'd17, channel = CH_INSPECT; otherwise channel = CH_BYPASS.
  - The result is latched in cur_ch and applied to every beat of the packet, including the SOP beat itself.
- FSM states: IDLE and IN_PKT.
  - IDLE, accepted SOP without EOP: classify and go to IN_PKT.
  - IDLE, accepted SOP with EOP: classify, forward, stay in IDLE (single-beat packet).
  - IDLE, accepted beat without SOP: orphan beat; drop it (not forwarded), increment err_cnt, stay in IDLE.
  - IN_PKT, accepted beat without SOP: forward with cur_ch; on EOP go to IDLE.
  - IN_PKT, accepted beat with SOP (previous packet truncated): forward it, reclassify, increment err_cnt. Go to IDLE if EOP is also set, else stay in IN_PKT. The truncated packet is not repaired.
  - sop and eop on the same beat are legal in either state.
- Datapath: one output register stage plus a one-entry skid register.
  - Latency: an accepted beat appears on out_pkt_* on the next cycle when the output register is free.
  - The output register advances when !out_pkt_valid | out_pkt_ready. The skid register refills it first, preserving order.
  - A beat accepted while the output register is stalled goes into the skid register.
  - in_pkt_ready is registered and equals "skid register empty at the next edge". At most one beat can arrive after the output stalls, and it is absorbed by the skid register.
  - Sustained throughput is 1 beat/cycle while out_pkt_ready is high.
- Output stability: while out_pkt_valid & !out_pkt_ready, all out_pkt_* signals hold stable.
- in_pkt_almost_full is out_pkt_almost_full delayed by one flop.
- Reset mid-packet: the FSM returns to IDLE and both registers are cleared. Beats of the interrupted packet that arrive after reset are orphans and are dropped.

Optional Feature:
- Macro: PKT_CNT_EN.
- When defined:
  - Adds output ports cnt_inspect[31:0], cnt_bypass[31:0] and err_cnt[31:0]. All reset to 0 and wrap at 2^32.
  - cnt_inspect / cnt_bypass increment by one when an EOP beat leaves out_pkt (valid & ready), selected by out_pkt_channel.
  - err_cnt increments on every orphan-drop or truncation event. If both kinds occur in one cycle, it counts one.
- When undefined: those ports and registers are absent; datapath behaviour is identical.

Test Plan:
- 3-beat IPv4/TCP packet (ethertype 0x0800, proto 6), out_pkt_ready = 1 -> 3 output beats, channel 0 on all, first beat one cycle after acceptance; cnt_inspect = 1.
- Single-beat ARP frame (ethertype 0x0806, sop = eop = 1, empty = 20) -> one beat, channel 1, empty = 20; cnt_bypass = 1.
- Two back-to-back packets (UDP 2 beats, then IPv6 2 beats) with out_pkt_ready low for 3 cycles mid-stream -> in_pkt_ready drops within 2 cycles; no beat lost or duplicated; channels 0,0,1,1 in order.
- Beat with valid=1, sop=0 while in IDLE -> nothing emitted; err_cnt = 1; a following TCP packet passes with channel 0.
- SOP (TCP) beat, then a new SOP (ARP) beat before any EOP -> both beats forwarded, tagged 0 then 1; err_cnt = 1.
- rst asserted asynchronously mid-packet -> outputs 0 immediately; later non-SOP beats of that packet dropped; the next SOP is classified normally.
